lct_l1a_matcher: RTL and testbench



---
 rtl/lct_l1a_matcher_if.sv | 23 ++
 rtl/lct_l1a_matcher.sv | 170 +++++++++++++++++
 tb/tb_lct_l1a_matcher.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lct_l1a_matcher_if.sv
// Event record bus from the L1A matcher to the readout controller.
// Valid/ready handshake; record fields are held while valid is high and ready is low.
interface lct_l1a_matcher_if #(
  parameter int CNT_W = 24
);
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] evt_l1a_cnt;
  logic [7:0]       evt_match;
  logic             evt_alct;
  logic             evt_otmb;
  logic             evt_tmo;

  modport master (
    output evt_valid, evt_l1a_cnt, evt_match, evt_alct, evt_otmb, evt_tmo,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_l1a_cnt, evt_match, evt_alct, evt_otmb, evt_tmo,
    output evt_ready
  );
endinterface

// File: rtl/lct_l1a_matcher.sv
// Matches each accepted L1A against an LCT look-back window, collects ALCT/OTMB
// data-available flags in L1A order, and emits complete event records.
module lct_l1a_matcher #(
  parameter int MAX_DLY    = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int DAV_TMO    = 255,
  parameter int CNT_W      = 24,
  localparam int DLY_W     = $clog2(MAX_DLY),
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int TMO_W     = $clog2(DAV_TMO + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              l1a,
  input  logic [7:0]        lct,
  input  logic              alct_dav,
  input  logic              otmb_dav,
  input  logic [DLY_W-1:0]  lct_dly,
  input  logic [3:0]        win,
  input  logic [7:0]        kill,
  lct_l1a_matcher_if.master evt,
  output logic [CNT_W-1:0]  l1a_cnt,
  output logic              ovfl
);

  logic [7:0]            hist [MAX_DLY];
  logic [7:0]            match;
  logic [DLY_W:0]        win_lo;
  logic [DLY_W:0]        win_hi;

  logic [CNT_W-1:0]      f_cnt   [FIFO_DEPTH];
  logic [7:0]            f_match [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] f_alct;
  logic [FIFO_DEPTH-1:0] f_otmb;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W:0]        count;
  logic [PTR_W:0]        occ_after;

  logic [TMO_W-1:0]      tmo_cnt;
  logic                  head_new;

  logic                  acc_l1a;
  logic                  acc_alct;
  logic                  acc_otmb;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  head_vld;
  logic                  head_dav_done;
  logic                  head_tmo;
  logic                  head_done;
  logic                  pop;
  logic                  push;
  logic [FIFO_DEPTH-1:0] wr_clr;
  logic [FIFO_DEPTH-1:0] alct_sel;
  logic [FIFO_DEPTH-1:0] otmb_sel;
  logic                  alct_found;
  logic                  otmb_found;
  logic [PTR_W-1:0]      idx;

  // Look-back window: hist[j] holds lct from j+1 cycles ago, so the current lct never matches
  always_comb begin
    win_lo = {1'b0, lct_dly};
    win_hi = win_lo + {{(DLY_W-3){1'b0}}, win};
    match  = '0;
    for (int j = 0; j < MAX_DLY; j++) begin
      if ((DLY_W+1)'(j) >= win_lo && (DLY_W+1)'(j) <= win_hi)
        match = match | hist[j];
    end
    match = match & ~kill;
  end

  always_comb begin
    acc_l1a       = en & l1a;
    acc_alct      = en & alct_dav;
    acc_otmb      = en & otmb_dav;
    cnt_inc       = l1a_cnt + CNT_W'(1);
    head_vld      = (count != '0);
    head_dav_done = f_alct[rd_ptr] & f_otmb[rd_ptr];
    head_tmo      = head_vld & ~head_new & (tmo_cnt == TMO_W'(DAV_TMO));
    head_done     = head_vld & (head_dav_done | head_tmo);
    pop           = head_done & (~evt.evt_valid | evt.evt_ready);
    occ_after     = count - (PTR_W+1)'(pop);
    push          = acc_l1a & (occ_after != (PTR_W+1)'(FIFO_DEPTH));
    wr_clr        = push ? (FIFO_DEPTH'(1) << wr_ptr) : '0;
  end

  // Each DAV goes to the oldest resident entry still missing that flag
  always_comb begin
    alct_sel   = '0;
    otmb_sel   = '0;
    alct_found = 1'b0;
    otmb_found = 1'b0;
    idx        = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((PTR_W+1)'(k) < count) begin
        if (!alct_found && !f_alct[idx]) begin
          alct_sel[idx] = 1'b1;
          alct_found    = 1'b1;
        end
        if (!otmb_found && !f_otmb[idx]) begin
          otmb_sel[idx] = 1'b1;
          otmb_found    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < MAX_DLY; j++) hist[j] <= '0;
    end else begin
      hist[0] <= lct;
      for (int j = 1; j < MAX_DLY; j++) hist[j] <= hist[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_cnt[wr_ptr]   <= cnt_inc;
      f_match[wr_ptr] <= match;
    end
  end

  // Control: queue pointers, DAV flags, head timeout and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      f_alct          <= '0;
      f_otmb          <= '0;
      l1a_cnt         <= '0;
      ovfl            <= 1'b0;
      tmo_cnt         <= '0;
      head_new        <= 1'b1;
      evt.evt_valid   <= 1'b0;
      evt.evt_l1a_cnt <= '0;
      evt.evt_match   <= '0;
      evt.evt_alct    <= 1'b0;
      evt.evt_otmb    <= 1'b0;
      evt.evt_tmo     <= 1'b0;
    end else begin
      if (acc_l1a) l1a_cnt <= cnt_inc;
      if (acc_l1a && !push) ovfl <= 1'b1;
      f_alct <= (f_alct | ({FIFO_DEPTH{acc_alct}} & alct_sel)) & ~wr_clr;
      f_otmb <= (f_otmb | ({FIFO_DEPTH{acc_otmb}} & otmb_sel)) & ~wr_clr;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= occ_after + (PTR_W+1)'(push);
      head_new <= pop | ~head_vld;
      if (head_new)
        tmo_cnt <= '0;
      else if (head_vld && !head_done)
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (pop) begin
        evt.evt_valid   <= 1'b1;
        evt.evt_l1a_cnt <= f_cnt[rd_ptr];
        evt.evt_match   <= f_match[rd_ptr];
        evt.evt_alct    <= f_alct[rd_ptr];
        evt.evt_otmb    <= f_otmb[rd_ptr];
        evt.evt_tmo     <= head_tmo & ~head_dav_done;
      end else if (evt.evt_ready) begin
        evt.evt_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lct_l1a_matcher.sv
// Directed bench for lct_l1a_matcher: window matching, DAV attribution,
// timeout, overflow/back-pressure and asynchronous reset.
module tb_lct_l1a_matcher;

  localparam int DAV_TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        l1a;
  logic [7:0]  lct;
  logic        alct_dav;
  logic        otmb_dav;
  logic [5:0]  lct_dly;
  logic [3:0]  win;
  logic [7:0]  kill;
  logic [23:0] l1a_cnt;
  logic        ovfl;

  int n_chk  = 0;
  int n_fail = 0;
  int waited;
  logic [23:0] hold_cnt;
  logic [7:0]  hold_match;

  lct_l1a_matcher_if #(.CNT_W(24)) evt_if ();

  lct_l1a_matcher dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .l1a      (l1a),
    .lct      (lct),
    .alct_dav (alct_dav),
    .otmb_dav (otmb_dav),
    .lct_dly  (lct_dly),
    .win      (win),
    .kill     (kill),
    .evt      (evt_if),
    .l1a_cnt  (l1a_cnt),
    .ovfl     (ovfl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b1; l1a = 1'b0; lct = '0; alct_dav = 1'b0; otmb_dav = 1'b0;
    lct_dly = 6'd5; win = 4'd2; kill = '0; evt_if.evt_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", evt_if.evt_valid, 0);
    chk("rst_cnt",   l1a_cnt, 0);
    chk("rst_ovfl",  ovfl, 0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input string tag, input int max_cyc, output int n);
    n = 0;
    while (!evt_if.evt_valid && n < max_cyc) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, evt_if.evt_valid, 1);
  endtask

  task automatic match_case(input string tag, input logic [7:0] lct_val, input int gap,
                            input logic [5:0] dly, input logic [3:0] w,
                            input logic [7:0] kill_val, input logic [7:0] exp_match);
    do_reset();
    lct_dly = dly; win = w; kill = kill_val;
    if (gap == 0) begin
      lct = lct_val; l1a = 1'b1;
      tick();
    end else begin
      lct = lct_val;
      tick();
      lct = '0;
      repeat (gap - 1) tick();
      l1a = 1'b1;
      tick();
    end
    l1a = 1'b0; lct = '0; alct_dav = 1'b1; otmb_dav = 1'b1;
    tick();
    alct_dav = 1'b0; otmb_dav = 1'b0;
    chk({tag, "_early"}, evt_if.evt_valid, 0);
    tick();
    chk({tag, "_valid"}, evt_if.evt_valid, 1);
    chk({tag, "_cnt"},   evt_if.evt_l1a_cnt, 1);
    chk({tag, "_match"}, evt_if.evt_match, exp_match);
    chk({tag, "_flags"}, {evt_if.evt_alct, evt_if.evt_otmb, evt_if.evt_tmo}, 3'b110);
    tick();
    chk({tag, "_1cyc"},  evt_if.evt_valid, 0);
  endtask

  initial begin
    // Window matching against the look-back history
    match_case("m_base",  8'h08, 6,  6'd5,  4'd2,  8'h00, 8'h08);
    match_case("m_late",  8'h08, 9,  6'd5,  4'd2,  8'h00, 8'h00);
    match_case("m_kill",  8'h08, 6,  6'd5,  4'd2,  8'h08, 8'h00);
    match_case("m_hi",    8'h81, 8,  6'd5,  4'd2,  8'h00, 8'h81);
    match_case("m_early", 8'h10, 5,  6'd5,  4'd2,  8'h00, 8'h00);
    match_case("m_same",  8'hFF, 0,  6'd0,  4'd15, 8'h00, 8'h00);
    match_case("m_kpart", 8'h09, 6,  6'd5,  4'd2,  8'h08, 8'h01);
    match_case("m_max",   8'h40, 64, 6'd63, 4'd15, 8'h00, 8'h40);
    match_case("m_j0",    8'h02, 1,  6'd0,  4'd0,  8'h00, 8'h02);

    // Disabled inputs are ignored
    do_reset();
    en = 1'b0; l1a = 1'b1; alct_dav = 1'b1; otmb_dav = 1'b1;
    tick();
    en = 1'b1; l1a = 1'b0; alct_dav = 1'b0; otmb_dav = 1'b0;
    repeat (3) tick();
    chk("en_cnt",   l1a_cnt, 0);
    chk("en_valid", evt_if.evt_valid, 0);

    // Timeout completion
    do_reset();
    l1a = 1'b1;
    tick();
    l1a = 1'b0;
    wait_valid("tmo", 400, waited);
    chk("tmo_lat",   waited, DAV_TMO + 2);
    chk("tmo_cnt",   evt_if.evt_l1a_cnt, 1);
    chk("tmo_flags", {evt_if.evt_alct, evt_if.evt_otmb, evt_if.evt_tmo}, 3'b001);

    // Overflow and back-pressure
    do_reset();
    evt_if.evt_ready = 1'b0;
    repeat (5) begin
      l1a = 1'b1;
      tick();
    end
    l1a = 1'b0;
    chk("ov_cnt",  l1a_cnt, 5);
    chk("ov_flag", ovfl, 1);
    wait_valid("ov_r1", 400, waited);
    hold_cnt = evt_if.evt_l1a_cnt; hold_match = evt_if.evt_match;
    chk("ov_r1_cnt", hold_cnt, 1);
    repeat (3) tick();
    chk("ov_hold_v", evt_if.evt_valid, 1);
    chk("ov_hold_c", evt_if.evt_l1a_cnt, hold_cnt);
    chk("ov_hold_m", evt_if.evt_match, hold_match);
    evt_if.evt_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_valid("ov_rec", 400, waited);
      chk("ov_rec_cnt", evt_if.evt_l1a_cnt, k);
      chk("ov_rec_tmo", evt_if.evt_tmo, 1);
      tick();
    end
    repeat (5) tick();
    chk("ov_no5", evt_if.evt_valid, 0);

    // In-order DAV attribution across two pending records
    do_reset();
    l1a = 1'b1; tick(); l1a = 1'b0; tick();
    l1a = 1'b1; tick(); l1a = 1'b0;
    alct_dav = 1'b1; tick(); tick(); alct_dav = 1'b0;
    otmb_dav = 1'b1; tick(); tick(); otmb_dav = 1'b0;
    wait_valid("dav_r1", 10, waited);
    chk("dav_r1_cnt", evt_if.evt_l1a_cnt, 1);
    chk("dav_r1_fl",  {evt_if.evt_alct, evt_if.evt_otmb, evt_if.evt_tmo}, 3'b110);
    tick();
    wait_valid("dav_r2", 10, waited);
    chk("dav_r2_cnt", evt_if.evt_l1a_cnt, 2);
    chk("dav_r2_fl",  {evt_if.evt_alct, evt_if.evt_otmb, evt_if.evt_tmo}, 3'b110);
    tick();
    chk("dav_done", evt_if.evt_valid, 0);
    otmb_dav = 1'b1; tick(); otmb_dav = 1'b0;
    repeat (3) tick();
    chk("stray_v",    evt_if.evt_valid, 0);
    chk("stray_cnt",  l1a_cnt, 2);
    chk("stray_ovfl", ovfl, 0);
    l1a = 1'b1; tick(); l1a = 1'b0;
    alct_dav = 1'b1; tick(); alct_dav = 1'b0;
    repeat (5) tick();
    chk("stray_drop", evt_if.evt_valid, 0);
    otmb_dav = 1'b1; tick(); otmb_dav = 1'b0;
    wait_valid("stray_r3", 10, waited);
    chk("stray_r3_cnt", evt_if.evt_l1a_cnt, 3);
    chk("stray_r3_fl",  {evt_if.evt_alct, evt_if.evt_otmb, evt_if.evt_tmo}, 3'b110);

    // Asynchronous reset with records pending
    do_reset();
    evt_if.evt_ready = 1'b0;
    repeat (6) begin
      l1a = 1'b1;
      tick();
    end
    l1a = 1'b0;
    alct_dav = 1'b1; otmb_dav = 1'b1; tick(); alct_dav = 1'b0; otmb_dav = 1'b0;
    wait_valid("ar_pre", 5, waited);
    chk("ar_pre_ovfl", ovfl, 1);
    chk("ar_pre_cnt",  l1a_cnt, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", evt_if.evt_valid, 0);
    chk("ar_cnt",   l1a_cnt, 0);
    chk("ar_ovfl",  ovfl, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; evt_if.evt_ready = 1'b1;
    tick();
    l1a = 1'b1; tick(); l1a = 1'b0;
    alct_dav = 1'b1; otmb_dav = 1'b1; tick(); alct_dav = 1'b0; otmb_dav = 1'b0;
    wait_valid("ar_post", 5, waited);
    chk("ar_post_cnt", evt_if.evt_l1a_cnt, 1);
    chk("ar_post_m",   evt_if.evt_match, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
